mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 mux (i0..i3 data inputs, s0/s1 selects) among four requesters.
//  Grants one requester at a time and holds the grant while its request stays high.
//  Drives the mux selects from the granted index, so the mux output carries the owner's input.
//  Sits between the requesting sources and the mux_4to1 instance; the mux itself stays combinational.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one owner may hold the grant while others wait (HOLD_LIMIT_EN only)
//  CNT_W     5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk      in   1  single clock, rising edge
//  rst_n    in   1  asynchronous active-low reset
//  req      in   4  request per source; req[k] owns mux input ik
//  gnt      out  4  one-hot grant, registered; all-zero when idle
//  sel_s0   out  1  mux select s0 = granted index bit 1 (chooses i0/i1 pair vs i2/i3 pair)
//  sel_s1   out  1  mux select s1 = granted index bit 0 (chooses within pair)
//  busy     out  1  1 while any grant is active (= |gnt)
//  preempt  out  1  1-cycle pulse when a grant is revoked by the hold limit; constant 0 without HOLD_LIMIT_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0000, sel_s0=0, sel_s1=0, busy=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
//  Index map: i0={s0,s1}=00, i1=01, i2=10, i3=11. Selects always equal owner index while OWNED.
//  Priority: search starts at ptr and wraps (ptr, ptr+1, ... mod 4); first set req wins.
//  ptr update: on every new grant to index k, ptr <= (k+1) mod 4.
//  States:
//   IDLE:  req==0 -> stay; any req set -> OWNED, gnt/selects for winner visible next cycle (1-cycle latency).
//   OWNED: req[owner]=1 -> keep grant unchanged (other reqs ignored);
//          req[owner]=0 and other reqs set -> direct handoff: new winner's grant next cycle, no idle gap;
//          req[owner]=0 and no other req -> IDLE, gnt=0000 next cycle.
//  In IDLE the selects keep their last value (mux output stable; no glitch on release).
//  gnt is never more than one-hot; gnt, sel_s0/sel_s1 and busy change on the same edge.
//  Requests arriving on the same edge as a release compete normally under the updated ptr.
//  Request pulses shorter than one cycle that are not sampled on an edge are lost (no request latching).
//  rst_n asserted mid-grant: immediate return to reset values; first grant after release starts from index 0.
// CONFIGURATION
//  HOLD_LIMIT_EN defined:
//   hold_cnt clears on each new grant and increments each OWNED cycle (saturating at MAX_HOLD).
//   When hold_cnt==MAX_HOLD-1 and another req is set, the grant is revoked:
//    - next winner is chosen from the other reqs (search from owner+1);
//    - handoff takes effect on the next edge;
//    - preempt pulses high for that one cycle.
//   If no other req is pending, the owner keeps the grant and hold_cnt stays saturated until a competitor appears.
//   The revoked owner may re-win later under normal round-robin order.
//  HOLD_LIMIT_EN undefined: no counter is built; the owner holds the grant indefinitely; preempt tied 0.
// TESTING
//  1 Reset then req=0100 -> next cycle gnt=0100, {sel_s0,sel_s1}=10, busy=1; ptr now 3.
//  2 req=1111 from reset, drop owner req each grant -> grant order 0,1,2,3,0, direct handoff, no idle cycle.
//  3 Owner 1 holds, req=1010 for 40 cycles (macro off) -> gnt stays 0010 throughout, preempt=0.
//  4 HOLD_LIMIT_EN, MAX_HOLD=16, req=1010 held -> gnt 0010 for 16 cycles, then 1000 with preempt pulse, then 0010.
//  5 Grant to 3 then req=0000 -> gnt=0000, busy=0, selects stay 11; rst_n low mid-grant -> all outputs reset at once.
//  6 Random req stress (5k cycles) -> gnt always one-hot or zero, selects match gnt index, no requester starved.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter for four requesters that share one combinational 4:1
//   mux. The current owner keeps its one-hot grant while its request stays
//   high. The mux selects follow the owner's index:
//     sel_s0 = index bit 1, sel_s1 = index bit 0.
//   When the arbiter goes idle, the selects hold their last value so the mux
//   output does not glitch on release.
//
//   Optional feature (macro HOLD_LIMIT_EN):
//     A hold counter limits one owner to MAX_HOLD consecutive cycles while
//     other requesters wait. When the limit is reached, ownership is handed
//     to a competitor and preempt pulses for one cycle.
//     With the macro undefined, no counter is built and preempt is tied low.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel_s0,
    output logic       sel_s1,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] owner_reg, owner_next;   // also drives the mux selects
    logic [1:0] ptr_reg,   ptr_next;     // round-robin search start
    logic [3:0] gnt_reg,   gnt_next;

    logic       grant_new;               // a (new) owner is chosen this cycle
    logic [1:0] new_idx;

    // Round-robin pick: first set bit of r, searching base, base+1, ... (mod 4).
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from the farthest candidate to the nearest, so the nearest
        // set bit is the last one written and therefore wins.
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] rr_res;
    logic       rr_any;
    logic [1:0] rr_idx;

    assign rr_res = rr_pick(req, ptr_reg);
    assign rr_any = rr_res[2];
    assign rr_idx = rr_res[1:0];

`ifdef HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_reg;
    logic             preempt_reg, preempt_next;
    logic [3:0]       owner_onehot;
    logic [2:0]       other_res;
    logic             other_any;
    logic [1:0]       other_idx;

    // One-hot decode of the current owner, used to mask it out of the requests.
    for (genvar gi = 0; gi < 4; gi++) begin : g_owner_dec
        assign owner_onehot[gi] = (owner_reg == 2'(gi));
    end

    // A preempting handoff searches only the competitors, starting just after
    // the owner.
    assign other_res = rr_pick(req & ~owner_onehot, owner_reg + 2'd1);
    assign other_any = other_res[2];
    assign other_idx = other_res[1:0];

    // Hold counter: cleared on every new grant, counts OWNED cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else if (grant_new) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == OWNED && hold_cnt_reg != HOLD_SAT) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    // Preempt flag is registered so its pulse lines up with the new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preempt_reg <= 1'b0;
        end else begin
            preempt_reg <= preempt_next;
        end
    end

    assign preempt = preempt_reg;
`else
    assign preempt = 1'b0;
`endif

    // State, owner, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 2'd0;
            ptr_reg   <= 2'd0;
            gnt_reg   <= 4'b0000;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
        end
    end

    // Next-state logic: grant from IDLE, hold, hand off, release, or preempt.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        grant_new  = 1'b0;
        new_idx    = owner_reg;
`ifdef HOLD_LIMIT_EN
        preempt_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (rr_any) begin
                    state_next = OWNED;
                    grant_new  = 1'b1;
                    new_idx    = rr_idx;
                end
            end
            OWNED: begin
                if (req[owner_reg]) begin
`ifdef HOLD_LIMIT_EN
                    // Use ">=" rather than "==": an owner whose counter has
                    // already saturated, with no competitor waiting, must
                    // still be preempted as soon as a competitor appears.
                    if (hold_cnt_reg >= HOLD_LAST && other_any) begin
                        grant_new    = 1'b1;
                        new_idx      = other_idx;
                        preempt_next = 1'b1;
                    end
`endif
                end else if (rr_any) begin
                    // The owner released and someone else is waiting: hand
                    // off directly, with no idle cycle in between.
                    grant_new = 1'b1;
                    new_idx   = rr_idx;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase

        if (grant_new) begin
            owner_next = new_idx;
            ptr_next   = new_idx + 2'd1;
        end
    end

    // One-hot grant decode, evaluated from the next state and next owner.
    for (genvar gi = 0; gi < 4; gi++) begin : g_gnt_dec
        assign gnt_next[gi] = (state_next == OWNED) && (owner_next == 2'(gi));
    end

    assign gnt    = gnt_reg;
    assign sel_s0 = owner_reg[1];
    assign sel_s1 = owner_reg[0];
    assign busy   = |gnt_reg;

endmodule
